// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive path.
// Frame word layout (32-bit words, word 1 carries sop):
//   1: dst[47:16]   2: {dst[15:0], src[47:32]}   3: src[31:0]   4: {16'h0, ethertype}
//   ARP 5-11: {htype,ptype} {hlen,plen,oper} sha_hi {sha_lo,spa_hi} {spa_lo,tha_hi} tha_lo tpa
//   IP  5-11: {ver,ihl,tos,tlen} {id,flags,off} {ttl,proto,csum} sip dip {sport,dport} {ulen,ucsum}
//   UDP payload from word 12.
package eth_pkg;

    localparam int unsigned WCNT_W = 16;

    localparam logic [15:0] ETYPE_ARP     = 16'h0806;
    localparam logic [15:0] ETYPE_IP      = 16'h0800;
    localparam logic [15:0] ARP_HTYPE     = 16'h0001;
    localparam logic [15:0] ARP_PTYPE     = 16'h0800;
    localparam logic [15:0] ARP_OPER_REQ  = 16'd1;
    localparam logic [15:0] ARP_OPER_RESP = 16'd2;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;

    // Header word indices (word 1 is the sop word).
    localparam logic [15:0] W_MAC_LO      = 16'd2;
    localparam logic [15:0] W_ETYPE       = 16'd4;
    localparam logic [15:0] W_HDR_FIRST   = 16'd5;
    localparam logic [15:0] W_HDR_OPER    = 16'd6;
    localparam logic [15:0] W_ARP_SHA_HI  = 16'd7;
    localparam logic [15:0] W_ARP_SHA_LO  = 16'd8;
    localparam logic [15:0] W_ARP_SPA_LO  = 16'd9;
    localparam logic [15:0] W_IP_FRAG     = 16'd6;
    localparam logic [15:0] W_IP_PROTO    = 16'd7;
    localparam logic [15:0] W_IP_DST      = 16'd9;
    localparam logic [15:0] W_IP_PORTS    = 16'd10;
    localparam logic [15:0] W_HDR_LAST    = 16'd11;
    localparam logic [15:0] W_PAY_FIRST   = 16'd12;

    typedef enum logic [2:0] {
        IDLE, ETH, ARP, IP, PAY, DROP, DONE
    } rx_state_e;

endpackage

// File: rtl/eth_ip_csum.sv
// IPv4 header checksum accumulator: 16-bit one's-complement sum with
// end-around carry over both halves of each enabled 32-bit word.
// Ports: clk, rst_n; clr restarts the sum; en folds data into the sum;
//        sum_c is the sum including the current data word (combinational).
module eth_ip_csum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] data,
    output logic [15:0] sum_c
);

    logic [15:0] acc;
    logic [17:0] raw_c;
    logic [16:0] fold_c;

    // Two fold steps are enough: a carry out of the first fold leaves a small low half.
    always_comb begin
        raw_c  = {2'b00, acc} + {2'b00, data[31:16]} + {2'b00, data[15:0]};
        fold_c = {1'b0, raw_c[15:0]} + {15'd0, raw_c[17:16]};
        sum_c  = fold_c[15:0] + {15'd0, fold_c[16]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= sum_c;
    end

endmodule

// File: rtl/eth_recv.sv
// Ethernet frame receiver: filters by MAC/IP, handles ARP request/reply,
// and writes UDP payload for LISTEN_PORT into a word RAM.
// Ports: clk, rst_n; frame stream i_data/i_vld/i_sop/i_eop/o_rdy;
//        local addresses i_self_mac/i_self_ip; RAM write o_wr_addr/o_wr_data/o_wr_en;
//        o_udp_done/o_udp_len; o_arp_req/o_arp_resp/o_peer_mac/o_peer_ip; o_err.
// Build option: ETH_RECV_IP_CSUM_EN enables IPv4 header checksum checking.
module eth_recv
    import eth_pkg::*;
#(
    parameter logic [15:0]  LISTEN_PORT = 16'd2179,
    parameter int unsigned  RAM_AW      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       i_data,
    input  logic              i_vld,
    input  logic              i_sop,
    input  logic              i_eop,
    output logic              o_rdy,
    input  logic [47:0]       i_self_mac,
    input  logic [31:0]       i_self_ip,
    output logic [RAM_AW-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_wr_en,
    output logic              o_udp_done,
    output logic [15:0]       o_udp_len,
    output logic              o_arp_req,
    output logic              o_arp_resp,
    output logic [47:0]       o_peer_mac,
    output logic [31:0]       o_peer_ip,
    output logic              o_err
);

    rx_state_e         state, nxt;
    logic [WCNT_W-1:0] wcnt;
    logic              mac_self, mac_bc;
    logic [15:0]       oper, udp_len;
    logic [47:0]       sha;
    logic [31:0]       spa;
    logic [RAM_AW:0]   wptr;

    logic              acc_c, full_c, mac_lo_ok_c, arp_bad_c, ip_bad_c, csum_bad_c;
    logic [WCNT_W-1:0] idx_c;
    logic [15:0]       udp_len_c;
    logic              err_c, wr_c, udp_done_c, arp_req_c, arp_resp_c;

    assign acc_c  = i_vld && o_rdy;
    assign idx_c  = i_sop ? WCNT_W'(1) : wcnt;
    assign full_c = wptr[RAM_AW];

    // Word 1 sets the per-frame match flags; word 2 completes the dst MAC.
    assign mac_lo_ok_c = (mac_self && (i_data[31:16] == i_self_mac[15:0])) ||
                         (mac_bc   && (i_data[31:16] == 16'hFFFF));

    assign arp_bad_c = ((idx_c == W_HDR_FIRST) && (i_data != {ARP_HTYPE, ARP_PTYPE})) ||
                       ((idx_c == W_HDR_LAST)  && (i_data != i_self_ip));

    assign ip_bad_c = ((idx_c == W_HDR_FIRST) && (i_data[31:24] != IP_VER_IHL)) ||
                      ((idx_c == W_IP_FRAG)   && (i_data[13] || (i_data[12:0] != 13'd0))) ||
                      ((idx_c == W_IP_PROTO)  && (i_data[23:16] != IP_PROTO_UDP)) ||
                      ((idx_c == W_IP_DST)    && (i_data != i_self_ip)) ||
                      ((idx_c == W_IP_PORTS)  && (i_data[15:0] != LISTEN_PORT)) ||
                      csum_bad_c;

`ifdef ETH_RECV_IP_CSUM_EN
    logic        csum_en_c;
    logic [15:0] csum_sum_c;

    assign csum_en_c = acc_c && !i_sop && (state == IP) &&
                       (idx_c >= W_HDR_FIRST) && (idx_c <= W_IP_DST);

    eth_ip_csum u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_c && i_sop),
        .en    (csum_en_c),
        .data  (i_data),
        .sum_c (csum_sum_c)
    );

    assign csum_bad_c = (idx_c == W_IP_DST) && (csum_sum_c != 16'hFFFF);
`else
    assign csum_bad_c = 1'b0;
`endif

    // A zero-length UDP payload ends on word 11, before udp_len is registered.
    assign udp_len_c = (state == IP) ? i_data[31:16] : udp_len;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state and pulse decode.
    always_comb begin
        nxt   = state;
        err_c = 1'b0;
        wr_c  = 1'b0;
        case (state)
            IDLE: ;
            ETH: if (acc_c) begin
                if (i_eop) begin
                    nxt   = IDLE;
                    err_c = 1'b1;
                end else if ((idx_c == W_MAC_LO) && !mac_lo_ok_c) begin
                    nxt = DROP;
                end else if (idx_c == W_ETYPE) begin
                    if (i_data[15:0] == ETYPE_ARP)     nxt = ARP;
                    else if (i_data[15:0] == ETYPE_IP) nxt = IP;
                    else                               nxt = DROP;
                end
            end
            ARP: if (acc_c) begin
                if (arp_bad_c) begin
                    nxt = i_eop ? IDLE : DROP;
                end else if (i_eop) begin
                    if (idx_c < W_HDR_LAST) begin
                        nxt   = IDLE;
                        err_c = 1'b1;
                    end else begin
                        nxt = DONE;
                    end
                end
            end
            IP: if (acc_c) begin
                if (ip_bad_c) begin
                    nxt   = i_eop ? IDLE : DROP;
                    err_c = csum_bad_c;
                end else if (i_eop) begin
                    if (idx_c < W_HDR_LAST) begin
                        nxt   = IDLE;
                        err_c = 1'b1;
                    end else begin
                        nxt = DONE;
                    end
                end else if (idx_c == W_PAY_FIRST - 16'd1) begin
                    nxt = PAY;
                end
            end
            PAY: if (acc_c) begin
                wr_c = !full_c;
                if (i_eop) begin
                    nxt   = full_c ? IDLE : DONE;
                    err_c = full_c;
                end
            end
            DROP: if (acc_c && i_eop) nxt = IDLE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // sop restarts parsing from any state; a single-word frame is truncated.
        if (acc_c && i_sop) begin
            nxt   = i_eop ? IDLE : ETH;
            err_c = i_eop;
            wr_c  = 1'b0;
        end
        udp_done_c = (nxt == DONE) && (state != ARP);
        arp_req_c  = (nxt == DONE) && (state == ARP) && (oper == ARP_OPER_REQ);
        arp_resp_c = (nxt == DONE) && (state == ARP) && (oper == ARP_OPER_RESP);
    end

    // Header capture, payload write and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt       <= '0;
            mac_self   <= 1'b0;
            mac_bc     <= 1'b0;
            oper       <= '0;
            udp_len    <= '0;
            sha        <= '0;
            spa        <= '0;
            wptr       <= '0;
            o_rdy      <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_wr_en    <= 1'b0;
            o_udp_done <= 1'b0;
            o_udp_len  <= '0;
            o_arp_req  <= 1'b0;
            o_arp_resp <= 1'b0;
            o_peer_mac <= '0;
            o_peer_ip  <= '0;
            o_err      <= 1'b0;
        end else begin
            o_rdy      <= (nxt != DONE);
            o_err      <= err_c;
            o_wr_en    <= wr_c;
            o_udp_done <= udp_done_c;
            o_arp_req  <= arp_req_c;
            o_arp_resp <= arp_resp_c;

            // wcnt holds the index of the next word; it saturates on giant frames.
            if (acc_c) begin
                if (i_sop)                   wcnt <= WCNT_W'(2);
                else if (wcnt != '1)         wcnt <= wcnt + WCNT_W'(1);
            end

            if (acc_c && i_sop) begin
                mac_self <= (i_data == i_self_mac[47:16]);
                mac_bc   <= (i_data == 32'hFFFF_FFFF);
                wptr     <= '0;
            end

            if (acc_c && !i_sop && (state == ARP)) begin
                case (idx_c)
                    W_HDR_OPER:   oper       <= i_data[15:0];
                    W_ARP_SHA_HI: sha[47:16] <= i_data;
                    W_ARP_SHA_LO: {sha[15:0], spa[31:16]} <= i_data;
                    W_ARP_SPA_LO: spa[15:0]  <= i_data[31:16];
                    default: ;
                endcase
            end

            if (acc_c && !i_sop && (state == IP) && (idx_c == W_HDR_LAST))
                udp_len <= i_data[31:16];

            if (wr_c) begin
                o_wr_data <= i_data;
                o_wr_addr <= wptr[RAM_AW-1:0];
                wptr      <= wptr + (RAM_AW+1)'(1);
            end

            if (udp_done_c)
                o_udp_len <= udp_len_c - 16'd8;

            if (arp_req_c || arp_resp_c) begin
                o_peer_mac <= sha;
                o_peer_ip  <= spa;
            end
        end
    end

endmodule

// File: tb/tb_eth_recv.sv
// Directed testbench for eth_recv: builds frames word by word, monitors the
// RAM write port and pulse outputs, and compares against hand-derived values.
module tb_eth_recv;

    localparam int unsigned AW       = 10;
    localparam logic [47:0] SELF_MAC = 48'h02AA_BBCC_DDEE;
    localparam logic [31:0] SELF_IP  = 32'hC0A8_0132;
    localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   i_data;
    logic          i_vld, i_sop, i_eop;
    logic          o_rdy;
    logic [AW-1:0] o_wr_addr;
    logic [31:0]   o_wr_data;
    logic          o_wr_en, o_udp_done, o_arp_req, o_arp_resp, o_err;
    logic [15:0]   o_udp_len;
    logic [47:0]   o_peer_mac;
    logic [31:0]   o_peer_ip;

    eth_recv #(.LISTEN_PORT(16'd2179), .RAM_AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (i_data),
        .i_vld      (i_vld),
        .i_sop      (i_sop),
        .i_eop      (i_eop),
        .o_rdy      (o_rdy),
        .i_self_mac (SELF_MAC),
        .i_self_ip  (SELF_IP),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_wr_en    (o_wr_en),
        .o_udp_done (o_udp_done),
        .o_udp_len  (o_udp_len),
        .o_arp_req  (o_arp_req),
        .o_arp_resp (o_arp_resp),
        .o_peer_mac (o_peer_mac),
        .o_peer_ip  (o_peer_ip),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor statistics, cleared per test.
    int          n_wr, n_addr_bad, n_data_bad, n_done, n_req, n_resp, n_err, n_rdy_low;
    logic [15:0] last_len;
    logic [AW-1:0] last_addr;
    logic [31:0] pay_base;

    always @(negedge clk) begin
        if (o_wr_en) begin
            if (o_wr_addr !== AW'(n_wr))             n_addr_bad++;
            if (o_wr_data !== pay_base + 32'(n_wr))  n_data_bad++;
            last_addr = o_wr_addr;
            n_wr++;
        end
        if (o_udp_done) begin
            n_done++;
            last_len = o_udp_len;
        end
        if (o_arp_req)  n_req++;
        if (o_arp_resp) n_resp++;
        if (o_err)      n_err++;
        if (rst_n && !o_rdy) n_rdy_low++;
    end

    task automatic clear_stats();
        @(posedge clk);
        n_wr = 0; n_addr_bad = 0; n_data_bad = 0; n_done = 0;
        n_req = 0; n_resp = 0; n_err = 0; n_rdy_low = 0;
        last_len = '0; last_addr = '0;
    endtask

    logic [31:0] frm[$];

    function automatic logic [15:0] ip_csum(input logic [31:0] a, b, c, d, e);
        logic [31:0] s;
        s = 32'(a[31:16]) + 32'(a[15:0]) + 32'(b[31:16]) + 32'(b[15:0]) +
            32'(c[31:16]) + 32'(c[15:0]) + 32'(d[31:16]) + 32'(d[15:0]) +
            32'(e[31:16]) + 32'(e[15:0]);
        while (s[31:16] != 16'd0) s = 32'(s[15:0]) + 32'(s[31:16]);
        return ~s[15:0];
    endfunction

    task automatic push_eth(input logic [47:0] dmac, input logic [15:0] etype);
        frm.delete();
        frm.push_back(dmac[47:16]);
        frm.push_back({dmac[15:0], 16'h0200});
        frm.push_back(32'h0000_0001);
        frm.push_back({16'h0000, etype});
    endtask

    task automatic build_arp(input logic [47:0] dmac, input logic [15:0] oper,
                             input logic [47:0] sha, input logic [31:0] spa,
                             input logic [31:0] tpa);
        push_eth(dmac, 16'h0806);
        frm.push_back(32'h0001_0800);
        frm.push_back({16'h0604, oper});
        frm.push_back(sha[47:16]);
        frm.push_back({sha[15:0], spa[31:16]});
        frm.push_back({spa[15:0], 16'h0000});
        frm.push_back(32'h0000_0000);
        frm.push_back(tpa);
    endtask

    task automatic build_udp(input logic [47:0] dmac, input logic [15:0] dport,
                             input logic [15:0] ulen, input int npay,
                             input logic [31:0] base, input bit bad_csum);
        logic [31:0] w5, w6, w7, w8, w9;
        logic [15:0] cs;
        w5 = {8'h45, 8'h00, ulen + 16'd20};
        w6 = 32'h1234_4000;
        w7 = 32'h4011_0000;
        w8 = 32'hC0A8_010A;
        w9 = SELF_IP;
        cs = ip_csum(w5, w6, w7, w8, w9);
        if (bad_csum) cs = cs ^ 16'h0100;
        push_eth(dmac, 16'h0800);
        frm.push_back(w5);
        frm.push_back(w6);
        frm.push_back({w7[31:16], cs});
        frm.push_back(w8);
        frm.push_back(w9);
        frm.push_back({16'h1F40, dport});
        frm.push_back({ulen, 16'h0000});
        for (int k = 0; k < npay; k++) frm.push_back(base + 32'(k));
    endtask

    // Send frm[first..last]; sop on frm[first] if sop, eop on frm[last] if eop.
    task automatic send_range(input int first, input int last, input bit sop, input bit eop);
        int tries;
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            i_data = frm[i];
            i_vld  = 1'b1;
            i_sop  = sop && (i == first);
            i_eop  = eop && (i == last);
            tries  = 0;
            while (!o_rdy && tries < 16) begin
                @(negedge clk);
                tries++;
            end
            if (tries >= 16) check("rdy_timeout", 64'(tries), 64'(0));
        end
        @(negedge clk);
        i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_all();
        send_range(0, frm.size() - 1, 1'b1, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t required < 2000000", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; i_data = '0; i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
        pay_base = '0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_ctrl", 64'({o_rdy, o_wr_en, o_udp_done, o_arp_req, o_arp_resp, o_err}), 64'd0);
        check("rst_wr", 64'({o_wr_addr, o_wr_data}), 64'd0);
        check("rst_peer", 64'(o_peer_mac) | 64'(o_peer_ip) | 64'(o_udp_len), 64'd0);
        rst_n = 1'b1;
        check("rdy_at_release", 64'(o_rdy), 64'd0);
        @(negedge clk);
        check("rdy_after_clk", 64'(o_rdy), 64'd1);

        // ARP request broadcast for us.
        clear_stats();
        build_arp(BCAST, 16'd1, 48'h0200_0000_0001, 32'hC0A8_010A, SELF_IP);
        send_all();
        check("arp_req_cnt", 64'(n_req), 64'd1);
        check("arp_req_resp_cnt", 64'(n_resp), 64'd0);
        check("arp_req_mac", 64'(o_peer_mac), 64'h0200_0000_0001);
        check("arp_req_ip", 64'(o_peer_ip), 64'hC0A8_010A);
        check("arp_req_err", 64'(n_err + n_done + n_wr), 64'd0);
        check("arp_req_rdy_low", 64'(n_rdy_low), 64'd1);

        // ARP reply unicast.
        clear_stats();
        build_arp(SELF_MAC, 16'd2, 48'h0211_2233_4455, 32'hC0A8_010B, SELF_IP);
        send_all();
        check("arp_resp_cnt", 64'(n_resp), 64'd1);
        check("arp_resp_req_cnt", 64'(n_req), 64'd0);
        check("arp_resp_mac", 64'(o_peer_mac), 64'h0211_2233_4455);
        check("arp_resp_ip", 64'(o_peer_ip), 64'hC0A8_010B);

        // ARP for another host: ignored, peer holds.
        clear_stats();
        build_arp(BCAST, 16'd1, 48'h0233_3333_3333, 32'hC0A8_0163, 32'hC0A8_0199);
        send_all();
        check("arp_other_pulses", 64'(n_req + n_resp + n_err), 64'd0);
        check("arp_other_mac_hold", 64'(o_peer_mac), 64'h0211_2233_4455);

        // UDP 300 payload words to the listen port.
        clear_stats();
        pay_base = 32'hA000_0000;
        build_udp(SELF_MAC, 16'd2179, 16'd1208, 300, pay_base, 1'b0);
        send_all();
        check("udp300_writes", 64'(n_wr), 64'd300);
        check("udp300_addr", 64'(n_addr_bad), 64'd0);
        check("udp300_data", 64'(n_data_bad), 64'd0);
        check("udp300_last_addr", 64'(last_addr), 64'd299);
        check("udp300_done", 64'(n_done), 64'd1);
        check("udp300_len", 64'(last_len), 64'd1200);
        check("udp300_err", 64'(n_err), 64'd0);
        check("udp300_rdy_low", 64'(n_rdy_low), 64'd1);

        // Wrong port: silently dropped.
        clear_stats();
        build_udp(SELF_MAC, 16'd5152, 16'd1208, 20, pay_base, 1'b0);
        send_all();
        check("port5152_writes", 64'(n_wr), 64'd0);
        check("port5152_pulses", 64'(n_done + n_err + n_req + n_resp), 64'd0);
        check("port5152_rdy_low", 64'(n_rdy_low), 64'd0);

        // Wrong destination MAC: silently dropped.
        clear_stats();
        build_udp(48'h02AA_BBCC_DDEF, 16'd2179, 16'd16, 2, pay_base, 1'b0);
        send_all();
        check("badmac_quiet", 64'(n_wr + n_done + n_err), 64'd0);

        // Truncated header: eop at word 7.
        clear_stats();
        build_udp(SELF_MAC, 16'd2179, 16'd1208, 300, pay_base, 1'b0);
        send_range(0, 6, 1'b1, 1'b1);
        check("trunc_err", 64'(n_err), 64'd1);
        check("trunc_quiet", 64'(n_wr + n_done), 64'd0);
        // Stray non-sop words are ignored, then a short frame is received normally.
        clear_stats();
        send_range(20, 23, 1'b0, 1'b1);
        pay_base = 32'h5500_0000;
        build_udp(SELF_MAC, 16'd2179, 16'd16, 2, pay_base, 1'b0);
        send_all();
        check("after_trunc_writes", 64'(n_wr), 64'd2);
        check("after_trunc_done", 64'(n_done), 64'd1);
        check("after_trunc_len", 64'(last_len), 64'd8);
        check("after_trunc_bad", 64'(n_addr_bad + n_data_bad + n_err), 64'd0);

        // sop at payload word 20 aborts the first frame.
        clear_stats();
        pay_base = 32'hB000_0000;
        build_udp(SELF_MAC, 16'd2179, 16'd1208, 300, pay_base, 1'b0);
        send_range(0, 11 + 19 - 1, 1'b1, 1'b0);
        check("abort_f1_writes", 64'(n_wr), 64'd19);
        check("abort_f1_done", 64'(n_done + n_err), 64'd0);
        clear_stats();
        pay_base = 32'hC000_0000;
        build_udp(SELF_MAC, 16'd2179, 16'd28, 5, pay_base, 1'b0);
        send_all();
        check("abort_f2_writes", 64'(n_wr), 64'd5);
        check("abort_f2_addr", 64'(n_addr_bad + n_data_bad), 64'd0);
        check("abort_f2_done", 64'(n_done), 64'd1);
        check("abort_f2_len", 64'(last_len), 64'd20);

        // Corrupted IP header checksum.
        clear_stats();
        pay_base = 32'hD000_0000;
        build_udp(SELF_MAC, 16'd2179, 16'd20, 3, pay_base, 1'b1);
        send_all();
`ifdef ETH_RECV_IP_CSUM_EN
        check("csum_err", 64'(n_err), 64'd1);
        check("csum_quiet", 64'(n_wr + n_done), 64'd0);
`else
        check("csum_ignored_writes", 64'(n_wr), 64'd3);
        check("csum_ignored_done", 64'(n_done), 64'd1);
        check("csum_ignored_len", 64'(last_len), 64'd12);
        check("csum_ignored_err", 64'(n_err), 64'd0);
`endif

        // Payload one word past RAM depth: writes stop at the last address.
        clear_stats();
        pay_base = 32'hE000_0000;
        build_udp(SELF_MAC, 16'd2179, 16'd4108, 1025, pay_base, 1'b0);
        send_all();
        check("ovf_writes", 64'(n_wr), 64'd1024);
        check("ovf_last_addr", 64'(last_addr), 64'd1023);
        check("ovf_addr", 64'(n_addr_bad + n_data_bad), 64'd0);
        check("ovf_err", 64'(n_err), 64'd1);
        check("ovf_done", 64'(n_done), 64'd0);

        // Reset mid-frame: outputs clear and the tail of the frame is ignored.
        pay_base = 32'hF000_0000;
        build_udp(SELF_MAC, 16'd2179, 16'd168, 40, pay_base, 1'b0);
        send_range(0, 13, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_peer", 64'(o_peer_mac) | 64'(o_peer_ip), 64'd0);
        check("midrst_wr", 64'({o_wr_en, o_wr_addr}), 64'd0);
        rst_n = 1'b1;
        clear_stats();
        send_range(14, frm.size() - 1, 1'b0, 1'b1);
        check("midrst_tail_quiet", 64'(n_wr + n_done + n_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
